// File: rtl/AHB_package.sv
// Shared AHB encodings, arbiter state type and burst beat-count constants
// for the slave_3 arbiter and its round-robin picker.
package AHB_package;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SINGLE = 2'd1,
    ARB_BURST  = 2'd2,
    ARB_LOCKED = 2'd3
  } arb_state_e;

  // Beats still to come after the NONSEQ beat that won the grant.
  localparam logic [3:0] BEATS_NONE = 4'd0;
  localparam logic [3:0] BEATS_4    = 4'd3;
  localparam logic [3:0] BEATS_8    = 4'd7;
  localparam logic [3:0] BEATS_16   = 4'd15;

  // Counter load for a burst type; zero means undefined length (SINGLE/INCR).
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] v;
    case (hburst_e'(hburst))
      HBURST_WRAP4,  HBURST_INCR4:  v = BEATS_4;
      HBURST_WRAP8,  HBURST_INCR8:  v = BEATS_8;
      HBURST_WRAP16, HBURST_INCR16: v = BEATS_16;
      default:                      v = BEATS_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: returns the first requesting channel
// found when scanning upward from i_ptr, wrapping from N-1 back to 0.
module ahb_rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_vld
);
  localparam int         IW  = $clog2(N);
  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] w_k;

  // Scan channels in priority order and latch onto the first requester.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_k   = '0;
    for (int i = 0; i < N; i++) begin
      w_k = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_k >= N_W) begin
        w_k = w_k - N_W;
      end else begin
        w_k = w_k;
      end
      if (!o_vld && i_req[w_k[IW-1:0]]) begin
        o_vld              = 1'b1;
        o_idx              = w_k[IW-1:0];
        o_gnt[w_k[IW-1:0]] = 1'b1;
      end else begin
        o_vld = o_vld;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_slave_3.sv
// Round-robin arbiter in front of slave_3. Grants are decided on hready_in
// edges only; fixed-length bursts and locked sequences keep the grant until
// they complete, are aborted, or the lock is released.
module ahb_arbiter_slave_3
  import AHB_package::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int RR_INIT     = 0
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [CHANNEL_NUM-1:0]           hreq,
  input  logic [CHANNEL_NUM-1:0][1:0]      htrans_in,
  input  logic [CHANNEL_NUM-1:0][2:0]      hburst_in,
  input  logic [CHANNEL_NUM-1:0]           hmastlock_in,
  input  logic                             hready_in,
  output logic [CHANNEL_NUM-1:0]           sel_addr,
  output logic [CHANNEL_NUM-1:0]           sel_data,
  output logic [$clog2(CHANNEL_NUM)-1:0]   hmaster,
  output logic                             hmastlock_out
);
  localparam int IW = $clog2(CHANNEL_NUM);

  arb_state_e             r_state;
  logic [3:0]             r_cnt;
  logic [IW-1:0]          r_ptr;
  logic [CHANNEL_NUM-1:0] r_sel_addr;
  logic [CHANNEL_NUM-1:0] r_sel_data;
  logic [IW-1:0]          r_hmaster;
  logic                   r_hmastlock;

  logic [CHANNEL_NUM-1:0] w_gnt;
  logic [IW-1:0]          w_gnt_idx;
  logic                   w_gnt_vld;
  htrans_e                w_own_trans;
  logic                   w_own_lock;
  logic                   w_win_lock;
  logic [3:0]             w_win_load;
  logic [IW-1:0]          w_ptr_nxt;
  logic                   w_rearb;

  ahb_rr_picker #(
    .N (CHANNEL_NUM)
  ) u_picker (
    .i_req (hreq),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_vld (w_gnt_vld)
  );

  // Attributes of the current owner and of the candidate winner.
  assign w_own_trans = htrans_e'(htrans_in[r_hmaster]);
  assign w_own_lock  = hmastlock_in[r_hmaster];
  assign w_win_lock  = hmastlock_in[w_gnt_idx];
  assign w_win_load  = burst_beats(hburst_in[w_gnt_idx]);
  assign w_ptr_nxt   = (w_gnt_idx == IW'(CHANNEL_NUM - 1)) ? '0 : (w_gnt_idx + IW'(1));

  // Decide whether the grant may move on this cycle.
  always_comb begin
    w_rearb = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_rearb = 1'b1;
      end
      ARB_SINGLE: begin
        if (w_own_lock) begin
          w_rearb = 1'b0;
        end else if (w_own_trans == HTRANS_IDLE || w_own_trans == HTRANS_NONSEQ) begin
          w_rearb = 1'b1;
        end else begin
          w_rearb = 1'b0;
        end
      end
      ARB_BURST: begin
        if (w_own_lock) begin
          w_rearb = 1'b0;
        end else if (w_own_trans == HTRANS_IDLE || w_own_trans == HTRANS_NONSEQ) begin
          // early termination by the owner
          w_rearb = 1'b1;
        end else if (w_own_trans == HTRANS_SEQ && r_cnt <= 4'd1) begin
          // last beat accepted: hand over back-to-back
          w_rearb = 1'b1;
        end else begin
          w_rearb = 1'b0;
        end
      end
      ARB_LOCKED: begin
        w_rearb = !w_own_lock;
      end
      default: begin
        w_rearb = 1'b1;
      end
    endcase
  end

  // Arbiter FSM, beat counter, priority pointer and registered selects.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ARB_IDLE;
      r_cnt       <= 4'd0;
      r_ptr       <= IW'(RR_INIT);
      r_sel_addr  <= '0;
      r_sel_data  <= '0;
      r_hmaster   <= '0;
      r_hmastlock <= 1'b0;
    end else if (hready_in) begin
      r_sel_data <= r_sel_addr;
      if (w_rearb) begin
        if (w_gnt_vld) begin
          r_sel_addr  <= w_gnt;
          r_hmaster   <= w_gnt_idx;
          r_ptr       <= w_ptr_nxt;
          r_hmastlock <= w_win_lock;
          if (w_win_lock) begin
            r_state <= ARB_LOCKED;
            r_cnt   <= 4'd0;
          end else if (w_win_load != BEATS_NONE) begin
            r_state <= ARB_BURST;
            r_cnt   <= w_win_load;
          end else begin
            r_state <= ARB_SINGLE;
            r_cnt   <= 4'd0;
          end
        end else begin
          // nobody asking: slave sees an all-zero (IDLE) transfer
          r_state     <= ARB_IDLE;
          r_cnt       <= 4'd0;
          r_sel_addr  <= '0;
          r_hmaster   <= '0;
          r_hmastlock <= 1'b0;
        end
      end else begin
        r_hmastlock <= w_own_lock;
        if (w_own_lock) begin
          r_state <= ARB_LOCKED;
          r_cnt   <= 4'd0;
        end else if (r_state == ARB_BURST && w_own_trans == HTRANS_SEQ) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          // BUSY or undefined-length SEQ: hold everything
          r_cnt <= r_cnt;
        end
      end
    end else begin
      r_state <= r_state;
    end
  end

  assign sel_addr      = r_sel_addr;
  assign sel_data      = r_sel_data;
  assign hmaster       = r_hmaster;
  assign hmastlock_out = r_hmastlock;

endmodule

// File: tb/tb_ahb_arbiter_slave_3.sv
// Directed bench for the slave_3 arbiter (two channels, RR_INIT=0).
// Observed word is {sel_addr, sel_data, hmaster, hmastlock_out}.
module tb_ahb_arbiter_slave_3;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NS     = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic            HCLK;
  logic            HRESET;
  logic [1:0]      hreq;
  logic [1:0][1:0] htrans_in;
  logic [1:0][2:0] hburst_in;
  logic [1:0]      hmastlock_in;
  logic            hready_in;
  logic [1:0]      sel_addr;
  logic [1:0]      sel_data;
  logic [0:0]      hmaster;
  logic            hmastlock_out;

  int n_tests;
  int n_fail;

  ahb_arbiter_slave_3 #(
    .CHANNEL_NUM (2),
    .RR_INIT     (0)
  ) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .hreq          (hreq),
    .htrans_in     (htrans_in),
    .hburst_in     (hburst_in),
    .hmastlock_in  (hmastlock_in),
    .hready_in     (hready_in),
    .sel_addr      (sel_addr),
    .sel_data      (sel_data),
    .hmaster       (hmaster),
    .hmastlock_out (hmastlock_out)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic set_ch(input logic ch, input logic req, input logic [1:0] tr,
                        input logic [2:0] bu, input logic lk);
    hreq[ch]         = req;
    htrans_in[ch]    = tr;
    hburst_in[ch]    = bu;
    hmastlock_in[ch] = lk;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {sel_addr, sel_data, hmaster, hmastlock_out};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    hreq      = 2'b00;
    htrans_in = '0;
    hburst_in = '0;
    hmastlock_in = 2'b00;
    hready_in = 1'b1;
    HRESET    = 1'b1;
    set_ch(1'b0, 1'b1, T_NS, B_SINGLE, 1'b0);
    set_ch(1'b1, 1'b1, T_NS, B_SINGLE, 1'b0);

    // reset with both channels requesting
    step(); chk("rst_c1", 6'b00_00_0_0);
    step(); chk("rst_c2", 6'b00_00_0_0);
    HRESET = 1'b0;

    // single transfers alternate
    step(); chk("rr_e1", 6'b01_00_0_0);
    step(); chk("rr_e2", 6'b10_01_1_0);
    step(); chk("rr_e3", 6'b01_10_0_0);
    step(); chk("rr_e4", 6'b10_01_1_0);

    // ch0 INCR4 while ch1 keeps requesting
    set_ch(1'b0, 1'b1, T_NS, B_INCR4, 1'b0);
    step(); chk("incr4_b1", 6'b01_10_0_0);
    set_ch(1'b0, 1'b0, T_SEQ, B_INCR4, 1'b0);
    step(); chk("incr4_b2", 6'b01_01_0_0);
    step(); chk("incr4_b3", 6'b01_01_0_0);
    step(); chk("incr4_b4_handover", 6'b10_01_1_0);

    // ch0 INCR8 with a 3-cycle wait and one BUSY
    set_ch(1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    set_ch(1'b0, 1'b1, T_NS, B_INCR8, 1'b0);
    step(); chk("incr8_b1", 6'b01_10_0_0);
    set_ch(1'b0, 1'b0, T_SEQ, B_INCR8, 1'b0);
    set_ch(1'b1, 1'b1, T_NS, B_SINGLE, 1'b0);
    step(); chk("incr8_b2", 6'b01_01_0_0);
    step(); chk("incr8_b3", 6'b01_01_0_0);
    hready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("incr8_wait", 6'b01_01_0_0);
    end
    hready_in = 1'b1;
    set_ch(1'b0, 1'b0, T_BUSY, B_INCR8, 1'b0);
    step(); chk("incr8_busy", 6'b01_01_0_0);
    set_ch(1'b0, 1'b0, T_SEQ, B_INCR8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("incr8_b4_b7", 6'b01_01_0_0);
    end
    step(); chk("incr8_b8_handover", 6'b10_01_1_0);

    // nobody requesting
    set_ch(1'b0, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    set_ch(1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    step(); chk("no_req", 6'b00_10_0_0);

    // ch1 locked for 6 cycles while ch0 requests
    set_ch(1'b1, 1'b1, T_NS, B_SINGLE, 1'b1);
    step(); chk("lock_grant", 6'b10_00_1_1);
    set_ch(1'b1, 1'b0, T_SEQ, B_SINGLE, 1'b1);
    set_ch(1'b0, 1'b1, T_NS, B_SINGLE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(); chk("lock_hold", 6'b10_10_1_1);
    end
    set_ch(1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    hready_in = 1'b0;
    step(); chk("lock_drop_wait", 6'b10_10_1_1);
    hready_in = 1'b1;
    step(); chk("lock_release", 6'b01_10_0_0);

    // ch0 INCR16 aborted after beat 5, ch1 waiting
    set_ch(1'b0, 1'b1, T_NS, B_INCR16, 1'b0);
    step(); chk("incr16a_b1", 6'b01_01_0_0);
    set_ch(1'b0, 1'b0, T_SEQ, B_INCR16, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("incr16a_hold", 6'b01_01_0_0);
    end
    set_ch(1'b0, 1'b0, T_IDLE, B_INCR16, 1'b0);
    set_ch(1'b1, 1'b1, T_NS, B_SINGLE, 1'b0);
    step(); chk("incr16a_abort", 6'b10_01_1_0);

    // ch0 INCR16 aborted after beat 5, nobody waiting
    set_ch(1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    set_ch(1'b0, 1'b1, T_NS, B_INCR16, 1'b0);
    step(); chk("incr16b_b1", 6'b01_10_0_0);
    set_ch(1'b0, 1'b0, T_SEQ, B_INCR16, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("incr16b_hold", 6'b01_01_0_0);
    end
    set_ch(1'b0, 1'b0, T_IDLE, B_INCR16, 1'b0);
    step(); chk("incr16b_abort", 6'b00_01_0_0);
    step(); chk("incr16b_idle", 6'b00_00_0_0);

    // reset in the middle of a burst
    set_ch(1'b0, 1'b1, T_NS, B_INCR4, 1'b0);
    step(); chk("rstb_grant", 6'b01_00_0_0);
    set_ch(1'b0, 1'b0, T_SEQ, B_INCR4, 1'b0);
    step(); chk("rstb_beat2", 6'b01_01_0_0);
    HRESET = 1'b1;
    set_ch(1'b0, 1'b1, T_NS, B_SINGLE, 1'b0);
    set_ch(1'b1, 1'b1, T_NS, B_SINGLE, 1'b0);
    step(); chk("rstb_reset", 6'b00_00_0_0);
    HRESET = 1'b0;
    step(); chk("rstb_first", 6'b01_00_0_0);
    step(); chk("rstb_second", 6'b10_01_1_0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
